// File: rtl/aes_engine_scheduler_if.sv
// Bundle of the requester, engine and output-stage signals around the
// AES engine scheduler. The scheduler uses the slave modport; the
// surrounding environment (requesters, engine, output stage) uses master.
interface aes_engine_scheduler_if #(
  parameter int DATA_W = 128
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_block;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_block;
  logic              req1_ready;
  logic              eng_start;
  logic [DATA_W-1:0] eng_plaintext;
  logic              eng_done;
  logic [DATA_W-1:0] eng_ciphertext;
  logic              transformer_done;
  logic [DATA_W-1:0] ciphertext;
  logic              output_read;
  logic              owner;
  logic              busy;
  logic              timeout_err;

  modport master (
    output req0_valid, req0_block, req1_valid, req1_block,
    output eng_done, eng_ciphertext, output_read,
    input  req0_ready, req1_ready, eng_start, eng_plaintext,
    input  transformer_done, ciphertext, owner, busy, timeout_err
  );

  modport slave (
    input  req0_valid, req0_block, req1_valid, req1_block,
    input  eng_done, eng_ciphertext, output_read,
    output req0_ready, req1_ready, eng_start, eng_plaintext,
    output transformer_done, ciphertext, owner, busy, timeout_err
  );
endinterface

// File: rtl/aes_engine_scheduler.sv
// Round-robin scheduler in front of the single AES round-transformer.
// Grants one of two requesters, launches the engine, captures its result,
// hands it to the output stage and waits for output_read before the next
// grant. All outputs are registered.
// Optional feature: define SCHED_TIMEOUT_EN to build the engine watchdog
// (TIMEOUT_CYCLES, 1..255); otherwise timeout_err is tied low.
module aes_engine_scheduler #(
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_,
  aes_engine_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ENG = 2'd1,
    WAIT_OUT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Registered outputs and arbitration history
  logic              ready0_q;
  logic              ready1_q;
  logic              start_q;
  logic              done_q;
  logic              tout_q;
  logic              owner_q;
  logic              busy_q;
  logic              last_q;
  logic [DATA_W-1:0] plain_q;
  logic [DATA_W-1:0] cipher_q;

  // Next values for the registered outputs
  logic              ready0_d;
  logic              ready1_d;
  logic              start_d;
  logic              done_d;
  logic              tout_d;
  logic              owner_d;
  logic              busy_d;
  logic              last_d;
  logic [DATA_W-1:0] plain_d;
  logic [DATA_W-1:0] cipher_d;

  logic grant0;
  logic grant1;
  logic grant;
  logic capture;
  logic expire;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  // On a tie the requester that was not served last wins; last_q resets to 1
  // so requester 0 takes the first tie.
  assign grant0  = (state == IDLE) && bus.req0_valid && (!bus.req1_valid || last_q);
  assign grant1  = (state == IDLE) && bus.req1_valid && (!bus.req0_valid || !last_q);
  assign grant   = grant0 || grant1;
  assign capture = (state == WAIT_ENG) && bus.eng_done;

`ifdef SCHED_TIMEOUT_EN
  logic [7:0] wd_cnt;

  // Watchdog: counts WAIT_ENG cycles without eng_done, cleared on each grant
  always_ff @(posedge clk) begin
    if (!rst_) begin
      wd_cnt <= 8'd0;
    end else if (grant) begin
      wd_cnt <= 8'd0;
    end else if ((state == WAIT_ENG) && !bus.eng_done) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

  // eng_done on the expiry edge takes precedence, so it masks expiry here
  assign expire = (state == WAIT_ENG) && !bus.eng_done &&
                  (wd_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant) state_nxt = WAIT_ENG;
      WAIT_ENG: begin
        if (capture)     state_nxt = WAIT_OUT;
        else if (expire) state_nxt = IDLE;
      end
      WAIT_OUT: if (bus.output_read) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output decode: next values of every registered output
  always_comb begin
    ready0_d = grant0;
    ready1_d = grant1;
    start_d  = grant;
    done_d   = capture;
    tout_d   = expire;
    busy_d   = (state_nxt != IDLE);
    owner_d  = owner_q;
    last_d   = last_q;
    plain_d  = plain_q;
    cipher_d = cipher_q;
    if (grant0) begin
      plain_d = bus.req0_block;
      owner_d = 1'b0;
      last_d  = 1'b0;
    end else if (grant1) begin
      plain_d = bus.req1_block;
      owner_d = 1'b1;
      last_d  = 1'b1;
    end
    if (capture) begin
      cipher_d = bus.eng_ciphertext;
    end
  end

  // Output registers; reset clears the block buffers too so an abandoned
  // block leaves nothing behind
  always_ff @(posedge clk) begin
    if (!rst_) begin
      ready0_q <= 1'b0;
      ready1_q <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      tout_q   <= 1'b0;
      busy_q   <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      plain_q  <= '0;
      cipher_q <= '0;
    end else begin
      ready0_q <= ready0_d;
      ready1_q <= ready1_d;
      start_q  <= start_d;
      done_q   <= done_d;
      tout_q   <= tout_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      plain_q  <= plain_d;
      cipher_q <= cipher_d;
    end
  end

  assign bus.req0_ready       = ready0_q;
  assign bus.req1_ready       = ready1_q;
  assign bus.eng_start        = start_q;
  assign bus.eng_plaintext    = plain_q;
  assign bus.transformer_done = done_q;
  assign bus.ciphertext       = cipher_q;
  assign bus.owner            = owner_q;
  assign bus.busy             = busy_q;
  assign bus.timeout_err      = tout_q;

endmodule

// File: doc/aes_engine_scheduler.md
# aes_engine_scheduler

Sequencing and arbitration front-end for the single AES round-transformer datapath. Two block requesters compete for the engine; the scheduler grants one at a time with round-robin fairness, launches the engine, captures the 128-bit result, and hands it to the byte-serial output stage via `transformer_done`/`ciphertext`. It holds off the next block until the output stage reports `output_read`. The scheduler sits between the host-side input ports and the round transformer / output interface pair.

## Interface
- `TIMEOUT_CYCLES`, default 64: engine watchdog limit in cycles, legal range 1..255. Used only with `SCHED_TIMEOUT_EN`.
- `clk`  in  1  sole clock; all logic on posedge.
- `rst_`  in  1  reset; synchronous and active-low.
- `req0_valid`  in  1  requester 0 has a block; held until `req0_ready` is seen.
- `req0_block`  in  128  requester 0 plaintext; stable while `req0_valid` is high.
- `req0_ready`  out  1  one-cycle accept pulse to requester 0.
- `req1_valid`, `req1_block`, `req1_ready`: same as requester 0, for requester 1.
- `eng_start`  out  1  one-cycle engine launch pulse.
- `eng_plaintext`  out  128  block to the engine; stable from `eng_start` until done or timeout.
- `eng_done`  in  1  engine completion, sampled only in `WAIT_ENG`.
- `eng_ciphertext`  in  128  engine result, valid when `eng_done` is high.
- `transformer_done`  out  1  one-cycle pulse to the output stage.
- `ciphertext`  out  128  captured result; held until the next capture or reset.
- `output_read`  in  1  output stage finished serializing, sampled only in `WAIT_OUT`.
- `owner`  out  1  index of the most recently granted requester.
- `busy`  out  1  high whenever state is not `IDLE`.
- `timeout_err`  out  1  one-cycle watchdog pulse. Constant 0 without `SCHED_TIMEOUT_EN`.

## Operation
- **States.** `IDLE`, `WAIT_ENG`, `WAIT_OUT`. All outputs are registered.
- **Reset.** At a clock edge with `rst_`=0:
  - state ← `IDLE`, `last` ← 1 (requester 0 wins the first tie).
  - `owner` ← 0; `busy` and all pulses ← 0.
  - `eng_plaintext` and `ciphertext` ← 0; watchdog counter ← 0.
- **IDLE arbitration.**
  - Only one valid: grant it.
  - Both valid: grant the requester ≠ `last`.
  - On grant at edge k:
    - latch that requester's block into `eng_plaintext`.
    - `owner` and `last` ← index.
    - `reqN_ready` = 1 and `eng_start` = 1 during cycle k+1.
    - state ← `WAIT_ENG`, counter ← 0.
- **WAIT_ENG.**
  - `eng_done` high at edge m: latch `eng_ciphertext` into `ciphertext`; `transformer_done` = 1 during cycle m+1; state ← `WAIT_OUT`.
  - `eng_done` is accepted from the first edge after grant.
- **WAIT_OUT.** `output_read` high at edge r: state ← `IDLE`. A new grant is possible at edge r+1.
- **Ignored inputs.** `eng_done` outside `WAIT_ENG` and `output_read` outside `WAIT_OUT` have no effect.
- **Ignored requests.** `reqN_valid` outside `IDLE` has no effect; requesters wait.
- **Reset mid-operation.** Abandons the block: no `transformer_done`, no `reqN_ready`. A later stray `eng_done` or `output_read` is ignored.

## Timing
- Grant latency: valid sampled in `IDLE` at edge k → ready/start high in cycle k+1.
- Done-to-handoff: 1 cycle.
- Minimum block period: 3 edges (grant, done, read) when the engine and output stage respond immediately.
- `reqN_ready`, `eng_start`, `transformer_done` and `timeout_err` are exactly one cycle wide.
- Requesters drop valid or change the block only after seeing ready.

## Configuration
- **`SCHED_TIMEOUT_EN` defined.**
  - Counter increments each `WAIT_ENG` cycle without `eng_done`.
  - On reaching `TIMEOUT_CYCLES`: `timeout_err` pulses for 1 cycle, state ← `IDLE`, no `transformer_done`, and `ciphertext` keeps its old value.
  - `eng_done` on the same edge as expiry wins; no error is raised.
  - `last` stays updated, so the other requester has priority next.
- **`SCHED_TIMEOUT_EN` not defined.**
  - `WAIT_ENG` waits indefinitely.
  - `timeout_err` is tied to 0; the counter is not built.

## Test plan
- **Reset.** Hold `rst_`=0 for 2 edges with both valids high → every output 0, `busy`=0, no ready.
- **Single requester 0.**
  - Stimulus: `req0_block`=128'h00112233445566778899aabbccddeeff; `eng_done` 3 cycles after start with `eng_ciphertext`=128'h69c4e0d86a7b0430d8cdb78070b4c55a; `output_read` 5 cycles later.
  - Response: one `req0_ready` and one `eng_start` in the same cycle; `transformer_done` 1 cycle after done; `ciphertext` matches; `owner`=0; `busy` low after read.
- **Contention.** Both valid continuously for 4 blocks → grants ordered 0,1,0,1; each grant only after the prior `output_read`.
- **Stray inputs.** `eng_done` pulsed in `IDLE` and in `WAIT_OUT`, and `output_read` pulsed in `WAIT_ENG` → no state change, no extra `transformer_done`.
- **Reset mid-operation.** `rst_`=0 for one edge during `WAIT_ENG`, then `eng_done` → stays `IDLE`, `ciphertext`=0, no `transformer_done`.
- **Watchdog.** With `SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, no `eng_done` → `timeout_err` pulses once 8 cycles after start, back to `IDLE`. With both valid, the next grant goes to requester 1.
